// File: rtl/instr_loader.sv
// Boot-time program loader: turns a byte stream (16-bit word count, then little-endian words)
// into instruction-memory writes, holding the CPU in reset until the whole image is in place.
module instr_loader #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, WRITE, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic [15:0]      n_hdr;
  logic [16:0]      idx_inc;

  assign accept  = byte_valid & ready_q;
  assign n_hdr   = {byte_data, cnt_q[7:0]};
  assign idx_inc = 17'(idx_q) + 17'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = byte_data;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_d  = n_hdr;
          idx_d  = '0;
          lane_d = '0;
          if (n_hdr == 16'd0)                      state_d = DONE;
          else if (32'(n_hdr) > 32'(MEM_WORDS))    state_d = ERR;
          else                                     state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            default: begin
              // Output registers only move here, so they hold between write strobes.
              wdata_d = {byte_data, word_q};
              addr_d  = BASE_ADDR + (32'(idx_q) << 2);
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_inc == {1'b0, cnt_q}) ? DONE : DATA;
      end
      default: ;
    endcase

    // Registered so that ready stays low until the first edge after reset release.
    ready_d = (state_d == CNT_LO) || (state_d == CNT_HI) ||
              (state_d == DATA)   || (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CNT_LO;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed vector table, randomized streams against a stream-level
// reference model, full-memory load and asynchronous reset sequences.
module tb_instr_loader;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, cpu_reset, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;

  instr_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           mode;       // 0 valid always, 1 toggling, 2 random
    int           nwr;
    logic [31:0]  first_data;
    logic [31:0]  last_addr;
    logic [31:0]  last_data;
    bit           done;
    bit           err;
    int           acc;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stim[$];
  logic [31:0] got_addr[$], got_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  int          acc_cnt, inv_bad, exp_acc;
  bit          exp_done, exp_err, timed_out;
  bit          fin_done, fin_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream-level expectation: which words land where, final status, and bytes consumed.
  task automatic model();
    int n;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_acc  = stim.size();
    if (stim.size() < 2) return;
    n = int'(stim[0]) + 256 * int'(stim[1]);
    if (n == 0) begin
      exp_done = 1'b1;
      exp_acc  = 2;
    end else if (n > MEM_WORDS) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4 * i + 3 >= stim.size()) break;
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
      end
      if (stim.size() >= 2 + 4 * n) begin
        exp_done = 1'b1;
        exp_acc  = 2 + 4 * n;
      end
    end
  endtask

  task automatic run_stream(input int mode);
    logic [31:0] la, ld;
    bit          have, prev_we, v, acc;
    int          idle, dcyc;
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    got_addr.delete();
    got_data.delete();
    acc_cnt = 0; inv_bad = 0; idle = 0; dcyc = 0;
    have = 1'b0; prev_we = 1'b0; la = '0; ld = '0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (imem_we) begin
        got_addr.push_back(imem_addr);
        got_data.push_back(imem_wdata);
      end
      if (imem_we && byte_ready) inv_bad++;
      if (imem_we && prev_we) inv_bad++;
      if (load_done && (byte_ready || cpu_reset || imem_we)) inv_bad++;
      if (!load_done && !cpu_reset) inv_bad++;
      if (load_err && (imem_we || !byte_ready)) inv_bad++;
      if (!byte_ready && !imem_we && !load_done) inv_bad++;
      if (!imem_we && have && (imem_addr !== la || imem_wdata !== ld)) inv_bad++;
      if (imem_we) begin la = imem_addr; ld = imem_wdata; have = 1'b1; end
      prev_we = imem_we;
      if (load_done) dcyc++;
      if (acc_cnt >= stim.size()) idle++;
      if (dcyc > 4 || idle > 6) begin
        timed_out = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = (acc_cnt < stim.size()) ? v : 1'b0;
      byte_data  = byte_valid ? stim[acc_cnt] : 8'($urandom);
      acc = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) acc_cnt++;
    end
    fin_done   = load_done;
    fin_err    = load_err;
    byte_valid = 1'b0;
    if (timed_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: stream of %0d bytes did not settle, accepted %0d", stim.size(), acc_cnt);
    end
  endtask

  task automatic compare_model(input string tag);
    int m;
    model();
    check({tag, " writes"}, 32'(got_data.size()), 32'(exp_data.size()));
    m = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, " done"}, 32'(fin_done), 32'(exp_done));
    check({tag, " err"}, 32'(fin_err), 32'(exp_err));
    check({tag, " accepted"}, 32'(acc_cnt), 32'(exp_acc));
    check({tag, " invariants"}, 32'(inv_bad), 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{128'({8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00}), 10, 0,
               2, 32'h00500513, 32'h4, 32'h00A00593, 1'b1, 1'b0, 10};
    tbl[1] = '{128'({8'h00, 8'h00, 8'h11, 8'h22}), 4, 0, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2};
    tbl[2] = '{128'({8'h41, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}), 10, 2,
               0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 10};
    tbl[3] = '{128'({8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}), 6, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6};
    tbl[4] = '{128'({8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}), 6, 1,
               1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 6};
    tbl[5] = '{128'({8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}), 9, 0,
               1, 32'h44332211, 32'h0, 32'h44332211, 1'b0, 1'b0, 9};
    tbl[6] = '{128'({8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}), 6, 0,
               1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 6};

    #1 reset = 1'b0;
    #1;
    check("rst byte_ready", 32'(byte_ready), 32'd0);
    check("rst cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst load_done", 32'(load_done), 32'd0);
    check("rst load_err", 32'(load_err), 32'd0);
    check("rst imem_we", 32'(imem_we), 32'd0);
    check("rst imem_addr", imem_addr, BASE);
    check("rst imem_wdata", imem_wdata, 32'h0);

    for (int t = 0; t < 7; t++) begin
      stim.delete();
      for (int i = 0; i < tbl[t].len; i++) stim.push_back(tbl[t].bytes[8*(tbl[t].len-1-i) +: 8]);
      run_stream(tbl[t].mode);
      check($sformatf("vec%0d writes", t), 32'(got_data.size()), 32'(tbl[t].nwr));
      if (tbl[t].nwr > 0 && got_data.size() > 0) begin
        check($sformatf("vec%0d first data", t), got_data[0], tbl[t].first_data);
        check($sformatf("vec%0d last addr", t), got_addr[got_addr.size()-1], tbl[t].last_addr);
        check($sformatf("vec%0d last data", t), got_data[got_data.size()-1], tbl[t].last_data);
      end
      check($sformatf("vec%0d done", t), 32'(fin_done), 32'(tbl[t].done));
      check($sformatf("vec%0d err", t), 32'(fin_err), 32'(tbl[t].err));
      check($sformatf("vec%0d accepted", t), 32'(acc_cnt), 32'(tbl[t].acc));
      check($sformatf("vec%0d invariants", t), 32'(inv_bad), 32'd0);
    end

    for (int t = 0; t < 12; t++) begin
      int kind, n, body;
      kind = $urandom_range(0, 4);
      case (kind)
        0:       n = $urandom_range(1, 6);
        1:       n = $urandom_range(1, 3);
        2:       n = $urandom_range(MEM_WORDS + 1, 400);
        3:       n = $urandom_range(2, 6);
        default: n = 0;
      endcase
      case (kind)
        1:       body = 4 * n + $urandom_range(1, 5);
        2:       body = $urandom_range(0, 6);
        3:       body = $urandom_range(1, 4 * n - 1);
        4:       body = $urandom_range(0, 3);
        default: body = 4 * n;
      endcase
      stim.delete();
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      for (int i = 0; i < body; i++) stim.push_back(8'($urandom));
      run_stream($urandom_range(0, 2));
      compare_model($sformatf("rand%0d", t));
    end

    stim.delete();
    stim.push_back(8'(MEM_WORDS));
    stim.push_back(8'h00);
    for (int i = 0; i < 4 * MEM_WORDS + 4; i++) stim.push_back(8'($urandom_range(1, 255)));
    run_stream(0);
    compare_model("full");
    check("full writes", 32'(got_data.size()), 32'(MEM_WORDS));
    check("full last addr", (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : 32'hFFFF_FFFF,
          BASE + 32'(4 * (MEM_WORDS - 1)));
    check("full accepted", 32'(acc_cnt), 32'(2 + 4 * MEM_WORDS));

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst byte_ready", 32'(byte_ready), 32'd0);
    check("async rst cpu_reset", 32'(cpu_reset), 32'd1);
    check("async rst load_done", 32'(load_done), 32'd0);
    check("async rst imem_addr", imem_addr, BASE);
    check("async rst imem_wdata", imem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release ready pre-edge", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release ready post-edge", 32'(byte_ready), 32'd1);
    check("release cpu_reset", 32'(cpu_reset), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
